// File: rtl/permutation_scheduler.sv
// ASCON permutation scheduler: sequences p^a / p^b rounds for one datapath.
// Latency: start accepted at edge T -> done_o pulse during cycle T+N+1 (N rounds).
// Backpressure: start_i taken only while ready_o=1; ignored while busy, never queued.
//
// Ports:
//   clock_i   - system clock, rising edge
//   reset_i   - asynchronous active-high reset, returns to IDLE
//   start_i   - request one permutation (sampled while ready_o=1)
//   mode_i    - 0: p^a (PA_ROUNDS), 1: p^b (PB_ROUNDS); sampled with start_i
//   ready_o   - 1 in IDLE and DONE
//   busy_o    - 1 in LOAD and RUN
//   select_o  - 1 = datapath loads external state (first round only)
//   round_o   - round index for the constant-addition layer
//   enable_o  - datapath state register enable
//   done_o    - one-cycle pulse, datapath holds the final state
//   abort_i   - (PERM_SCHED_ABORT_EN only) cancel a run in LOAD/RUN
//   aborted_o - (PERM_SCHED_ABORT_EN only) one-cycle pulse after an abort
//
// Optional feature macro: PERM_SCHED_ABORT_EN (adds abort_i / aborted_o).

module permutation_scheduler #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       enable_o,
  output logic       done_o
`ifdef PERM_SCHED_ABORT_EN
  ,
  input  logic       abort_i,
  output logic       aborted_o
`endif
);

  // Parameter legality, checked at elaboration.
  if (PA_ROUNDS < 1 || PA_ROUNDS > 12) begin : g_bad_pa
    $error("permutation_scheduler: PA_ROUNDS must be in 1..12");
  end
  if (PB_ROUNDS < 1 || PB_ROUNDS > PA_ROUNDS) begin : g_bad_pb
    $error("permutation_scheduler: PB_ROUNDS must be in 1..PA_ROUNDS");
  end

  // The final round is always 11 so the round index lines up with the
  // ASCON round-constant table; shorter permutations start later.
  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] PA_START   = 4'(12 - PA_ROUNDS);
  localparam logic [3:0] PB_START   = 4'(12 - PB_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       ready_q, busy_q, select_q, enable_q, done_q, aborted_q;
  logic       aborted_d;
  logic       abort_req;
  logic [3:0] start_round;

`ifdef PERM_SCHED_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // First round index for the requested permutation; evaluated at the
  // accepting edge, which is what latches mode_i.
  assign start_round = mode_i ? PB_START : PA_START;

  // Next-state logic. The round counter is compared against LAST_ROUND
  // before any increment, so it can never pass 11 or wrap.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start directly: back-to-back runs, no bubble.
        if (start_i) begin
          state_d = S_LOAD;
          round_d = start_round;
        end else begin
          state_d = S_IDLE;
          round_d = 4'd0;
        end
      end

      S_LOAD, S_RUN: begin
        // Abort wins over round progression, including the last round.
        if (abort_req) begin
          state_d   = S_IDLE;
          round_d   = 4'd0;
          aborted_d = 1'b1;
        end else if (round_q == LAST_ROUND) begin
          // Single-round permutations (N=1) reach here straight from LOAD.
          state_d = S_DONE;
          round_d = LAST_ROUND;
        end else begin
          state_d = S_RUN;
          round_d = round_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // State and registered outputs. Outputs are decoded from the next state
  // so they line up with the state they describe without a combinational
  // path from state_q to the ports.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      round_q   <= 4'd0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      select_q  <= 1'b0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      ready_q   <= (state_d == S_IDLE) || (state_d == S_DONE);
      busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN);
      select_q  <= (state_d == S_LOAD);
      enable_q  <= (state_d == S_LOAD) || (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      aborted_q <= aborted_d;
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign select_o = select_q;
  assign round_o  = round_q;
  assign enable_o = enable_q;
  assign done_o   = done_q;

`ifdef PERM_SCHED_ABORT_EN
  assign aborted_o = aborted_q;
`else
  // Aborts cannot happen in this build; the flop is constant zero.
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

  // Structural invariants of the schedule.
  a_round_range : assert property (@(posedge clock_i) disable iff (reset_i)
    round_o <= LAST_ROUND);
  a_ready_busy : assert property (@(posedge clock_i) disable iff (reset_i)
    ready_o != busy_o);
  a_select_en : assert property (@(posedge clock_i) disable iff (reset_i)
    select_o |-> enable_o);
  a_done_pulse : assert property (@(posedge clock_i) disable iff (reset_i)
    done_o |=> !done_o);
  a_done_round : assert property (@(posedge clock_i) disable iff (reset_i)
    done_o |-> (round_o == LAST_ROUND) && !enable_o);

endmodule

// File: tb/tb_permutation_scheduler.sv
// Randomised + directed bench for permutation_scheduler with a queue scoreboard.
// The model expands each accepted start into its per-cycle output schedule.
// A monitor thread pops one expected cycle per busy/done cycle and compares.

module tb_permutation_scheduler;

  localparam int PA = 12;
  localparam int PB = 6;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       ready_o, busy_o, select_o, enable_o, done_o;
  logic [3:0] round_o;
  logic       abort_tb = 1'b0;
`ifdef PERM_SCHED_ABORT_EN
  logic       aborted_o;
`endif

  permutation_scheduler #(.PA_ROUNDS(PA), .PB_ROUNDS(PB)) dut (
    .clock_i (clk),
    .reset_i (reset_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .select_o(select_o),
    .round_o (round_o),
    .enable_o(enable_o),
    .done_o  (done_o)
`ifdef PERM_SCHED_ABORT_EN
    ,
    .abort_i  (abort_tb),
    .aborted_o(aborted_o)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int rnd;
    bit sel;
    bit en;
    bit dn;
  } exp_t;

  exp_t q[$];
  int   rem = 0;        // cycles of the current run not yet elapsed
  bit   abort_exp = 0;  // aborted_o expected in the coming cycle
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference schedule: N rounds from 12-N up to 11, select on the first,
  // enable on all N, then a single done cycle holding round 11.
  task automatic model_edge(input logic s, input logic m, input logic a);
    bit was_busy;
    int n;
    was_busy  = (rem >= 2);
    if (rem > 0) rem--;
    abort_exp = 1'b0;
    if (a && was_busy) begin
      q.delete();
      rem       = 0;
      abort_exp = 1'b1;
    end else if (rem == 0 && s) begin
      n = m ? PB : PA;
      for (int k = 0; k < n; k++)
        q.push_back('{rnd: 12 - n + k, sel: (k == 0), en: 1'b1, dn: 1'b0});
      q.push_back('{rnd: 11, sel: 1'b0, en: 1'b0, dn: 1'b1});
      rem = n + 1;
    end
  endtask

  task automatic step(input logic s, input logic m, input logic a);
    start_i  = s;
    mode_i   = m;
`ifdef PERM_SCHED_ABORT_EN
    abort_tb = a;
`else
    abort_tb = 1'b0;
`endif
    @(posedge clk);
    model_edge(s, m, abort_tb);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_round"},  round_o,  0);
    chk({tag, "_select"}, select_o, 0);
    chk({tag, "_enable"}, enable_o, 0);
    chk({tag, "_done"},   done_o,   0);
    chk({tag, "_busy"},   busy_o,   0);
    chk({tag, "_ready"},  ready_o,  1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("round",  round_o,  e.rnd);
          chk("select", select_o, e.sel);
          chk("enable", enable_o, e.en);
          chk("done",   done_o,   e.dn);
          chk("busy",   busy_o,   e.en);
          chk("ready",  ready_o,  !e.en);
        end else begin
          chk("idle_round",  round_o,  0);
          chk("idle_select", select_o, 0);
          chk("idle_enable", enable_o, 0);
          chk("idle_done",   done_o,   0);
          chk("idle_ready",  ready_o,  1);
        end
`ifdef PERM_SCHED_ABORT_EN
        chk("aborted", aborted_o, abort_exp);
`endif
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Asynchronous reset: outputs settle without a clock edge.
    #2 reset_i = 1'b1;
    #1 chk_reset_outputs("reset_async");
    @(posedge clk);
    @(posedge clk);
    #3 reset_i = 1'b0;
    #1 chk("ready_after_reset", ready_o, 1);

    // p^a then p^b, single starts.
    step(1'b1, 1'b0, 1'b0);
    idle(14);
    step(1'b1, 1'b1, 1'b0);
    idle(8);

    // Start pulsed while busy (p^a, fourth cycle of the run) is ignored.
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    idle(12);

    // Back-to-back: start held high, accepted again during DONE.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(14);

    // Reset mid-run while round_o=5: immediate idle outputs, no done_o later.
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("round_before_reset", round_o, 5);
    #2 reset_i = 1'b1;
    #1 chk_reset_outputs("reset_midrun");
    q.delete();
    rem       = 0;
    abort_exp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_i = 1'b0;
    #1 chk("ready_after_midrun_reset", ready_o, 1);
    idle(4);

`ifdef PERM_SCHED_ABORT_EN
    // Abort during round 5, then abort while idle (ignored).
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
`endif

    // Randomised traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 24) == 0));

    idle(16);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
